// File: rtl/effect_noise_gate_pkg.sv
// Shared types and threshold helpers for the effect-chain noise gate.
// Purely declarative: no latency, no flow control.
package noise_gate_pkg;

    typedef enum logic [2:0] {
        OPEN,
        HOLD,
        RELEASE,
        CLOSED,
        ATTACK
    } gate_state_t;

    localparam logic signed [15:0] GAIN_UNITY = 16'sd32767;
    localparam int                 THR_BASE   = 64;

    function automatic logic [15:0] thr_close(input logic [2:0] thresh);
        return 16'(THR_BASE) << thresh;
    endfunction

    // Opening needs 1.5x the closing level so a signal hovering near the threshold does not chatter.
    function automatic logic [15:0] thr_open(input logic [15:0] close_lvl);
        return close_lvl + (close_lvl >> 1);
    endfunction

endpackage

// File: rtl/effect_noise_gate_envelope.sv
// Peak envelope follower: saturating |x|, instant attack, env>>ENV_SHIFT decay.
// env_next is combinational for the current sample; state advances only on valid; no backpressure.
module gate_envelope_follower #(
    parameter int ENV_SHIFT = 6
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic               i_clear,
    input  logic signed [15:0] i_data,
    output logic        [14:0] o_env_next
);

    logic [14:0] env_q;
    logic [14:0] env_d;
    logic [14:0] abs_val;

    always_comb begin
        abs_val = 15'(i_data[15] ? -i_data : i_data);
        // -32768 has no positive 16-bit twin; clamp to full scale.
        if (i_data == 16'sh8000) begin
            abs_val = 15'h7FFF;
        end
        if (abs_val > env_q) begin
            env_d = abs_val;
        end else begin
            env_d = env_q - (env_q >> ENV_SHIFT);
        end
    end

    assign o_env_next = env_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            env_q <= '0;
        end else if (i_valid) begin
            env_q <= i_clear ? 15'd0 : env_d;
        end
    end

endmodule

// File: rtl/effect_noise_gate.sv
// Noise gate with hysteresis, hold time and linear attack/release gain ramp; bypass when disabled.
// 1-sample registered latency, o_valid follows i_valid; strobe-driven, no backpressure.
module effect_noise_gate
    import noise_gate_pkg::*;
#(
    parameter int HOLD_SAMPLES = 2048,
    parameter int ENV_SHIFT    = 6,
    parameter int ATTACK_STEP  = 1024,
    parameter int RELEASE_STEP = 64
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic               i_enable,
    input  logic        [2:0]  i_thresh,
    input  logic signed [15:0] i_data,
    output logic signed [15:0] o_data,
    output logic               o_valid
);

    localparam int HOLD_W = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;

    gate_state_t        state_q, state_d;
    logic        [15:0] gain_q, gain_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic signed [15:0] data_q, data_d;
    logic               valid_q;

    logic        [14:0] env_next;
    logic        [15:0] env_ext;
    logic        [15:0] thr_c;
    logic        [15:0] thr_o;
    logic        [16:0] gain_sum;
    logic        [15:0] gain_up;
    logic        [15:0] gain_dn;
    logic signed [31:0] prod;
    logic signed [15:0] gated;

    gate_envelope_follower #(
        .ENV_SHIFT (ENV_SHIFT)
    ) u_env (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .i_clear    (!i_enable),
        .i_data     (i_data),
        .o_env_next (env_next)
    );

    assign env_ext = {1'b0, env_next};
    assign thr_c   = thr_close(i_thresh);
    assign thr_o   = thr_open(thr_c);

    always_comb begin
        gain_sum = 17'(gain_q) + 17'(ATTACK_STEP);
        gain_up  = (gain_sum >= 17'd32767) ? 16'h7FFF : gain_sum[15:0];
        gain_dn  = (gain_q > 16'(RELEASE_STEP)) ? gain_q - 16'(RELEASE_STEP) : 16'd0;
    end

    // Gain is Q1.15 and never exceeds 32767, so it is non-negative as a signed operand.
    assign prod = 32'(i_data) * 32'($signed(gain_q));

    always_comb begin
        if (gain_q == 16'h7FFF) begin
            gated = i_data;
        end else if (gain_q == 16'd0) begin
            gated = 16'sd0;
        end else begin
            gated = 16'(prod >>> 15);
        end
    end

    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        hold_d  = hold_q;
        data_d  = data_q;
        if (i_valid) begin
            if (!i_enable) begin
                data_d  = i_data;
                state_d = OPEN;
                gain_d  = 16'(GAIN_UNITY);
                hold_d  = '0;
            end else begin
                data_d = gated;
                case (state_q)
                    OPEN: begin
                        gain_d = 16'(GAIN_UNITY);
                        if (env_ext < thr_c) begin
                            state_d = HOLD;
                            hold_d  = HOLD_W'(HOLD_SAMPLES - 1);
                        end
                    end
                    HOLD: begin
                        if (env_ext >= thr_o) begin
                            state_d = OPEN;
                        end else if (hold_q == '0) begin
                            state_d = RELEASE;
                        end else begin
                            hold_d = hold_q - 1'b1;
                        end
                    end
                    RELEASE: begin
                        gain_d = gain_dn;
                        if (env_ext >= thr_o) begin
                            state_d = ATTACK;
                        end else if (gain_dn == 16'd0) begin
                            state_d = CLOSED;
                        end
                    end
                    CLOSED: begin
                        gain_d = 16'd0;
                        if (env_ext >= thr_o) begin
                            state_d = ATTACK;
                        end
                    end
                    ATTACK: begin
                        gain_d = gain_up;
                        if (gain_up == 16'h7FFF) begin
                            state_d = OPEN;
                        end else if (env_ext < thr_c) begin
                            state_d = RELEASE;
                        end
                    end
                    default: begin
                        state_d = OPEN;
                        gain_d  = 16'(GAIN_UNITY);
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= OPEN;
            gain_q  <= 16'(GAIN_UNITY);
            hold_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            valid_q <= i_valid;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;

endmodule

// File: tb/tb_effect_noise_gate.sv
// Scoreboarded bench: directed gate scenarios plus randomized segments against a behavioural model.
module tb_effect_noise_gate;

    localparam int HOLD_N = 4;
    localparam int ESHIFT = 6;
    localparam int ASTEP  = 1024;
    localparam int RSTEP  = 8192;

    localparam int S_OPEN = 0, S_HOLD = 1, S_REL = 2, S_CLOSED = 3, S_ATT = 4;

    logic               clk = 1'b0;
    logic               i_rst = 1'b1;
    logic               i_valid = 1'b0;
    logic               i_enable = 1'b0;
    logic        [2:0]  i_thresh = 3'd0;
    logic signed [15:0] i_data = 16'sd0;
    logic signed [15:0] o_data;
    logic               o_valid;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_q[$];
    logic        exp_vld = 1'b0;
    logic        mon_en  = 1'b0;
    logic [15:0] mon_e;

    int m_state, m_gain, m_env, m_hold;

    effect_noise_gate #(
        .HOLD_SAMPLES (HOLD_N),
        .ENV_SHIFT    (ESHIFT),
        .ATTACK_STEP  (ASTEP),
        .RELEASE_STEP (RSTEP)
    ) dut (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .i_enable (i_enable),
        .i_thresh (i_thresh),
        .i_data   (i_data),
        .o_data   (o_data),
        .o_valid  (o_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    task automatic check_ok(input string name, input bit ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: condition not reached (got 0, expected 1)", name);
        end
    endtask

    task automatic model_reset();
        m_state = S_OPEN;
        m_gain  = 32767;
        m_env   = 0;
        m_hold  = 0;
    endtask

    // Reference gate: plain integer arithmetic straight from the behavioural rules.
    task automatic model_step(input int d, input bit en, input int thr, output int out);
        int a, en_next, tc, to;
        if (!en) begin
            model_reset();
            out = d;
            return;
        end
        a = (d < 0) ? -d : d;
        if (a > 32767) a = 32767;
        en_next = (a > m_env) ? a : m_env - (m_env / (2 ** ESHIFT));
        tc = 64 * (2 ** thr);
        to = tc + tc / 2;
        if (m_gain == 32767)   out = d;
        else if (m_gain == 0)  out = 0;
        else                   out = (d * m_gain) >>> 15;
        case (m_state)
            S_OPEN: if (en_next < tc) begin m_state = S_HOLD; m_hold = HOLD_N - 1; end
            S_HOLD: begin
                if (en_next >= to)     m_state = S_OPEN;
                else if (m_hold == 0)  m_state = S_REL;
                else                   m_hold = m_hold - 1;
            end
            S_REL: begin
                m_gain = (m_gain - RSTEP < 0) ? 0 : m_gain - RSTEP;
                if (en_next >= to)     m_state = S_ATT;
                else if (m_gain == 0)  m_state = S_CLOSED;
            end
            S_CLOSED: begin
                m_gain = 0;
                if (en_next >= to) m_state = S_ATT;
            end
            default: begin
                m_gain = (m_gain + ASTEP > 32767) ? 32767 : m_gain + ASTEP;
                if (m_gain == 32767)   m_state = S_OPEN;
                else if (en_next < tc) m_state = S_REL;
            end
        endcase
        m_env = en_next;
    endtask

    task automatic send(input int d, input bit en, input int thr);
        int e;
        i_data   = 16'(d);
        i_enable = en;
        i_thresh = 3'(thr);
        i_valid  = 1'b1;
        model_step(d, en, thr, e);
        exp_q.push_back(16'(e));
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(posedge clk) exp_vld <= i_rst ? 1'b0 : i_valid;

    always @(negedge clk) begin
        if (mon_en) begin
            check("o_valid", {15'd0, o_valid}, {15'd0, exp_vld});
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    check_ok("unexpected_output", 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("o_data", o_data, mon_e);
                end
            end
        end
    end

    initial begin
        int k, amp, d, thr, len;
        int loud_tbl[3];
        int quiet_tbl[3];
        loud_tbl  = '{500, 5000, 32767};
        quiet_tbl = '{0, 40, 100};
        model_reset();
        idle(2);
        i_rst  = 1'b0;
        mon_en = 1'b1;
        check("reset_o_data", o_data, 16'd0);
        check("reset_o_valid", {15'd0, o_valid}, 16'd0);

        for (int i = 0; i < 10; i++) begin
            send(1000, 1'b1, 0);
            check("open_unity", o_data, 16'd1000);
        end

        send(-32768, 1'b0, 0);
        check("bypass_min", o_data, 16'h8000);
        send(32767, 1'b0, 0);
        check("bypass_max", o_data, 16'h7FFF);

        send(2000, 1'b1, 0);
        for (k = 0; k < 1000 && !(m_state == S_REL && m_gain == 16383); k++) send(0, 1'b1, 0);
        check_ok("reach_release_16383", m_state == S_REL && m_gain == 16383);
        send(4000, 1'b1, 0);
        check("release_gain_16383", o_data, 16'd1999);

        for (k = 0; k < 1000 && m_state != S_CLOSED; k++) send(0, 1'b1, 0);
        check_ok("reach_closed", m_state == S_CLOSED);

        for (int i = 0; i < 20; i++) begin
            send(80, 1'b1, 0);
            check("hyst_closed", o_data, 16'd0);
        end

        send(100, 1'b1, 0);
        check("attack_trigger", o_data, 16'd0);
        for (int i = 1; i <= 32; i++) begin
            send(100, 1'b1, 0);
            if (i == 32) check("attack_last_ramp", o_data, 16'd96);
        end
        send(100, 1'b1, 0);
        check("attack_done_unity", o_data, 16'd100);

        for (int i = 0; i < 40; i++) begin
            send(80, 1'b1, 0);
            check("hyst_open", o_data, 16'd80);
        end

        send(3000, 1'b1, 0);
        for (k = 0; k < 1000 && m_state != S_REL; k++) send(0, 1'b1, 0);
        check_ok("reach_release", m_state == S_REL);
        send(0, 1'b1, 0);
        send(60, 1'b1, 0);
        check("release_gain_24575", o_data, 16'd44);
        idle(1);
        i_rst = 1'b1;
        idle(1);
        check("midramp_rst_data", o_data, 16'd0);
        check("midramp_rst_valid", {15'd0, o_valid}, 16'd0);
        i_rst = 1'b0;
        model_reset();
        send(1234, 1'b1, 0);
        check("post_rst_unity", o_data, 16'd1234);

        for (int seg = 0; seg < 40; seg++) begin
            thr = $urandom_range(0, 7);
            len = $urandom_range(20, 120);
            send(int'($urandom_range(0, 2000)) - 1000, 1'b0, thr);
            for (int s = 0; s < len; s++) begin
                amp = (s < len / 3) ? loud_tbl[$urandom_range(0, 2)] : quiet_tbl[$urandom_range(0, 2)];
                d = int'($urandom_range(0, 2 * amp)) - amp;
                if ($urandom_range(0, 39) == 0) d = -32768;
                send(d, ($urandom_range(0, 49) != 0), thr);
                idle($urandom_range(0, 2));
            end
        end

        idle(3);
        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
